// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the scheduled UART transmitter.
//   state_t            - transmitter FSM states
//   DATA_BITS_DEFAULT  - default payload width per frame
//   LINE_IDLE/START/STOP - serial line levels for idle, start bit and stop bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    STOP
  } state_t;

  localparam int DATA_BITS_DEFAULT = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
//   req - request vector (N bits)
//   ptr - index where the search starts; the search wraps upward from here
//   gnt - one-hot grant for the first requester found (all zero if none)
//   idx - binary index of the granted requester (0 if none)
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;
  logic         found;

  // Walk the requesters starting at ptr; the first one asserted wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: several requesters share one UART transmit line. In IDLE a
// round-robin arbiter picks one requester, its byte is captured, and a frame
// (start bit, DATA_BITS data bits LSB-first, stop bit) is sent, each bit
// lasting one tick period.
//   clk   - clock
//   rst   - asynchronous active-low reset
//   tick  - baud strobe, one clk pulse per bit period
//   req   - per-requester transmit request
//   data  - flattened bytes, requester i at [i*DATA_BITS +: DATA_BITS]
//   grant - one-hot, one-clk accept pulse
//   owner - index of the requester whose frame is in flight
//   busy  - high from grant through end of stop bit
//   done  - one-clk pulse when the stop bit completes
//   tx    - registered serial line, idle high
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           busy,
  output logic                           done,
  output logic                           tx
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  state_t                 state_q,   state_d;
  logic                   tx_q,      tx_d;
  logic [NUM_REQ-1:0]     grant_q,   grant_d;
  logic                   done_q,    done_d;
  logic                   busy_q,    busy_d;
  logic [OW-1:0]          owner_q,   owner_d;
  logic [OW-1:0]          ptr_q,     ptr_d;
  logic [DATA_BITS-1:0]   shift_q,   shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [OW-1:0]          arb_idx;

  rr_arbiter #(
    .N (NUM_REQ),
    .W (OW)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    grant_d   = '0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      // A tick on the accept edge is deliberately not looked at here, so the
      // start bit always begins on a later tick and lasts a full period.
      IDLE: begin
        if (|req) begin
          grant_d = arb_gnt;
          owner_d = arb_idx;
          busy_d  = 1'b1;
          ptr_d   = (arb_idx == OW'(NUM_REQ - 1)) ? '0 : arb_idx + OW'(1);
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
              shift_d = data[i*DATA_BITS +: DATA_BITS];
            end
          end
          state_d = ARM;
        end
      end
      ARM: begin
        if (tick) begin
          tx_d    = LINE_START;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      // bit_cnt_q is the index of the bit currently on the line.
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
            tx_d    = LINE_STOP;
            state_d = STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tx_q      <= LINE_IDLE;
      grant_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign tx    = tx_q;
  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed testbench for uart_tx_sched (NUM_REQ=4,
// DATA_BITS=8). tick pulses every 4 clks unless disabled; inputs change and
// outputs are sampled on the falling clock edge.
module tb_uart_tx_sched;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  req  = 4'b0000;
  logic [31:0] data = 32'hC33C0FA5;  // bytes: r0=A5 r1=0F r2=3C r3=C3
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic        done;
  logic        tx;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit tick_en   = 1'b1;
  int phase     = 0;

  uart_tx_sched #(
    .NUM_REQ   (4),
    .DATA_BITS (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .req   (req),
    .data  (data),
    .grant (grant),
    .owner (owner),
    .busy  (busy),
    .done  (done),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    forever begin
      @(negedge clk);
      phase = (phase + 1) % 4;
      tick  = tick_en && (phase == 0);
    end
  end

  task automatic wait_grant(output logic [3:0] g, output bit ok);
    ok = 1'b0;
    g  = 4'b0000;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (grant !== 4'b0000) begin
        g  = grant;
        ok = 1'b1;
      end
    end
  endtask

  // Records the ten line levels of one frame, one sample per bit period, and
  // flags any level change inside a period or a stray grant/done/busy drop.
  task automatic capture_frame(output logic [9:0] bits, output bit frame_ok, output bit done_ok);
    bit started;
    started  = 1'b0;
    frame_ok = 1'b1;
    done_ok  = 1'b0;
    bits     = '1;
    for (int i = 0; i < 40 && !started; i++) begin
      @(negedge clk);
      if (tx === 1'b0) started = 1'b1;
      else if (grant !== 4'b0000 || done !== 1'b0 || busy !== 1'b1) frame_ok = 1'b0;
    end
    if (!started) begin
      frame_ok = 1'b0;
    end else begin
      for (int b = 0; b < 10; b++) begin
        bits[b] = tx;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (tx !== bits[b] || grant !== 4'b0000 || done !== 1'b0 || busy !== 1'b1)
            frame_ok = 1'b0;
        end
        @(negedge clk);
      end
      done_ok = (done === 1'b1) && (busy === 1'b0) && (tx === 1'b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b0000;
    repeat (3) @(negedge clk);
    total_cnt++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (owner !== 2'd0) $display("FAIL reset_owner: got %0d want 0", owner); else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    logic [3:0] exp_g;
    logic [7:0] exp_b;
    logic [9:0] bits;
    bit ok, fok, dok;
    int who;
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      who   = f % 4;
      exp_g = 4'b0001 << who;
      exp_b = data[who*8 +: 8];
      wait_grant(g, ok);
      total_cnt++;
      if (!ok || g !== exp_g) $display("FAIL rr_grant frame %0d: got %b want %b", f, g, exp_g);
      else pass_cnt++;
      total_cnt++;
      if (owner !== 2'(who)) $display("FAIL rr_owner frame %0d: got %0d want %0d", f, owner, who);
      else pass_cnt++;
      if (f == 4) req = 4'b0000;
      capture_frame(bits, fok, dok);
      total_cnt++;
      if (!fok || bits !== {1'b1, exp_b, 1'b0})
        $display("FAIL rr_frame frame %0d: got %b (clean=%0d) want %b", f, bits, fok, {1'b1, exp_b, 1'b0});
      else pass_cnt++;
      total_cnt++;
      if (!dok) $display("FAIL rr_done frame %0d: got done=%b busy=%b want done=1 busy=0", f, done, busy);
      else pass_cnt++;
    end
    req = 4'b0000;
  endtask

  task automatic test_single();
    logic [3:0] g;
    logic [9:0] bits;
    bit ok, fok, dok;
    req = 4'b0001;
    wait_grant(g, ok);
    total_cnt++; if (!ok || g !== 4'b0001) $display("FAIL single_grant: got %b want 0001", g); else pass_cnt++;
    total_cnt++; if (owner !== 2'd0) $display("FAIL single_owner: got %0d want 0", owner); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else pass_cnt++;
    req = 4'b0000;
    capture_frame(bits, fok, dok);
    total_cnt++;
    if (!fok || bits !== 10'b1101001010)
      $display("FAIL single_frame: got %b (clean=%0d) want 1101001010", bits, fok);
    else pass_cnt++;
    total_cnt++; if (!dok) $display("FAIL single_done: got done=%b busy=%b want 1/0", done, busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL single_after: got done=%b busy=%b want 0/0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [3:0] g;
    logic [9:0] bits;
    bit ok, fok, dok;
    req = 4'b0100;
    wait_grant(g, ok);
    total_cnt++; if (!ok || g !== 4'b0100) $display("FAIL wrap_first: got %b want 0100", g); else pass_cnt++;
    req = 4'b0101;
    capture_frame(bits, fok, dok);
    total_cnt++;
    if (!fok || !dok || bits !== 10'b1001111000)
      $display("FAIL wrap_frame2: got %b (clean=%0d done=%0d) want 1001111000", bits, fok, dok);
    else pass_cnt++;
    wait_grant(g, ok);
    total_cnt++; if (!ok || g !== 4'b0001) $display("FAIL wrap_to0: got %b want 0001", g); else pass_cnt++;
    capture_frame(bits, fok, dok);
    wait_grant(g, ok);
    total_cnt++; if (!ok || g !== 4'b0100) $display("FAIL wrap_then2: got %b want 0100", g); else pass_cnt++;
    req = 4'b0000;
    capture_frame(bits, fok, dok);
    total_cnt++; if (!dok) $display("FAIL wrap_done: got done=%b want 1", done); else pass_cnt++;
  endtask

  task automatic test_tick_on_grant();
    bit aligned;
    bit seen_done;
    int lat;
    int width;
    aligned = 1'b0;
    for (int i = 0; i < 8 && !aligned; i++) begin
      @(negedge clk);
      #1;
      if (tick === 1'b1) aligned = 1'b1;
    end
    req = 4'b0010;
    @(negedge clk);
    total_cnt++; if (grant !== 4'b0010) $display("FAIL tog_grant: got %b want 0010", grant); else pass_cnt++;
    total_cnt++; if (tx !== 1'b1) $display("FAIL tog_tx_idle: got %b want 1", tx); else pass_cnt++;
    req = 4'b0000;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(negedge clk);
      if (tx === 1'b0) lat = i;
    end
    total_cnt++; if (lat != 4) $display("FAIL tog_latency: got %0d clks want 4", lat); else pass_cnt++;
    width = 0;
    for (int i = 0; i < 12 && tx === 1'b0; i++) begin
      width++;
      @(negedge clk);
    end
    total_cnt++; if (width != 4) $display("FAIL tog_start_width: got %0d clks want 4", width); else pass_cnt++;
    seen_done = 1'b0;
    for (int i = 0; i < 60 && !seen_done; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    total_cnt++; if (!seen_done) $display("FAIL tog_done: got no done want done"); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] g;
    logic [9:0] bits;
    bit ok, fok, dok, started, dpulse;
    req = 4'b0001;
    wait_grant(g, ok);
    req = 4'b0000;
    started = 1'b0;
    for (int i = 0; i < 12 && !started; i++) begin
      @(negedge clk);
      if (tx === 1'b0) started = 1'b1;
    end
    repeat (16) @(negedge clk);  // first clk of data bit 3
    total_cnt++;
    if (!started || tx !== 1'b0) $display("FAIL rmid_bit3: got %b want 0", tx); else pass_cnt++;
    #1 rst = 1'b0;
    #1;
    total_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || grant !== 4'b0000 || done !== 1'b0)
      $display("FAIL rmid_async: got tx=%b busy=%b grant=%b done=%b want 1/0/0000/0", tx, busy, grant, done);
    else pass_cnt++;
    dpulse = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0 || tx !== 1'b1) dpulse = 1'b1;
    end
    rst = 1'b1;
    req = 4'b0010;
    wait_grant(g, ok);
    total_cnt++;
    if (!ok || g !== 4'b0010 || dpulse) $display("FAIL rmid_regrant: got %b (bad_hold=%0d) want 0010", g, dpulse);
    else pass_cnt++;
    total_cnt++; if (owner !== 2'd1) $display("FAIL rmid_owner: got %0d want 1", owner); else pass_cnt++;
    req = 4'b0000;
    capture_frame(bits, fok, dok);
    total_cnt++;
    if (!fok || !dok || bits !== 10'b1000011110)
      $display("FAIL rmid_frame: got %b (clean=%0d done=%0d) want 1000011110", bits, fok, dok);
    else pass_cnt++;
  endtask

  task automatic test_no_tick();
    logic [3:0] g;
    bit ok, started, held, seen_done;
    int chg;
    req = 4'b0001;
    wait_grant(g, ok);
    req = 4'b0000;
    started = 1'b0;
    for (int i = 0; i < 12 && !started; i++) begin
      @(negedge clk);
      if (tx === 1'b0) started = 1'b1;
    end
    repeat (10) @(negedge clk);  // inside data bit 1 (value 0)
    tick_en = 1'b0;
    total_cnt++;
    if (!started || tx !== 1'b0 || dut.bit_cnt_q !== 3'd1)
      $display("FAIL ntk_pre: got tx=%b cnt=%0d want 0/1", tx, dut.bit_cnt_q);
    else pass_cnt++;
    held = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b0 || dut.bit_cnt_q !== 3'd1 || busy !== 1'b1) held = 1'b0;
    end
    total_cnt++;
    if (!held) $display("FAIL ntk_hold: got tx=%b cnt=%0d want held at 0/1", tx, dut.bit_cnt_q);
    else pass_cnt++;
    tick_en = 1'b1;
    chg = 0;
    for (int i = 0; i < 12 && chg == 0; i++) begin
      @(negedge clk);
      if (tx !== 1'b0) chg = i + 1;
    end
    total_cnt++;
    if (chg == 0 || tx !== 1'b1 || dut.bit_cnt_q !== 3'd2)
      $display("FAIL ntk_resume: got tx=%b cnt=%0d after %0d clks want 1/2", tx, dut.bit_cnt_q, chg);
    else pass_cnt++;
    seen_done = 1'b0;
    for (int i = 0; i < 60 && !seen_done; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    total_cnt++; if (!seen_done) $display("FAIL ntk_done: got no done want done"); else pass_cnt++;
  endtask

  initial begin : main
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_tick_on_grant();
    test_reset_mid();
    test_no_tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
